// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: NBITS-wide UART transmitter with per-frame parity/stop selection and a ready/valid input.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry holding FIFO in front of the frame engine.
module uart_tx_cfg #(
    parameter int NBITS = 8,
    parameter int NTICK = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             tx_clk,
    input  logic             tx_rst,
    input  logic             bdtick,
    input  logic             tx_ena,
    input  logic [NBITS-1:0] data_in,
    input  logic [1:0]       par_mode,
    input  logic             stop2,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             txff_full
);
    localparam int TW = $clog2(NTICK);
    localparam int W = NBITS + 3;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [3:0] bcnt, bcnt_n;
    logic [NBITS-1:0] sreg, sreg_n;
    logic par, par_n, pen, pen_n, st2, st2_n, line_n;
    logic load, tick_end, stop_last;
    logic [W-1:0] word;
    assign tick_end = bdtick && tcnt == TW'(NTICK - 1);
    assign stop_last = !st2 || bcnt[0];
`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_n;
    logic push;
    assign push = tx_ena && !txff_full;
    assign load = state == IDLE && cnt != '0;
    assign word = mem[rp];
    assign tx_ready = !txff_full;
    assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(load);
    always_ff @(posedge tx_clk)
        if (push) mem[wp] <= {stop2, par_mode, data_in};
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            txff_full <= 1'b0;
        end else begin
            wp <= push ? wp + AW'(1) : wp;
            rp <= load ? rp + AW'(1) : rp;
            cnt <= cnt_n;
            txff_full <= cnt_n == (AW+1)'(FIFO_DEPTH);
        end
    end
`else
    assign load = state == IDLE && tx_ena;
    assign word = {stop2, par_mode, data_in};
    assign tx_ready = state == IDLE;
    assign txff_full = FIFO_DEPTH == 0;
`endif
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state <= IDLE;
            tcnt <= '0;
            bcnt <= '0;
            sreg <= '0;
            par <= 1'b0;
            pen <= 1'b0;
            st2 <= 1'b0;
            tx_out <= 1'b1;
        end else begin
            state <= state_n;
            tcnt <= tcnt_n;
            bcnt <= bcnt_n;
            sreg <= sreg_n;
            par <= par_n;
            pen <= pen_n;
            st2 <= st2_n;
            tx_out <= line_n;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = load ? START : IDLE;
            START:   state_n = tick_end ? DATA : START;
            DATA:    if (tick_end && bcnt == 4'(NBITS - 1)) state_n = pen ? PARITY : STOP;
            PARITY:  state_n = tick_end ? STOP : PARITY;
            STOP:    state_n = (tick_end && stop_last) ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    // tx_out is registered, so the line level is derived from next-state values
    always_comb begin
        tcnt_n = (state_n != state || state == IDLE || tick_end) ? '0 : bdtick ? tcnt + TW'(1) : tcnt;
        bcnt_n = (state_n != state) ? '0 : (tick_end && (state == DATA || state == STOP)) ? bcnt + 4'd1 : bcnt;
        sreg_n = load ? word[NBITS-1:0] : (state == DATA && tick_end) ? sreg >> 1 : sreg;
        par_n = load ? (^word[NBITS-1:0]) ^ (word[NBITS+1:NBITS] == 2'b10) : par;
        pen_n = load ? ^word[NBITS+1:NBITS] : pen;
        st2_n = load ? word[NBITS+2] : st2;
        line_n = state_n == START ? 1'b0 : state_n == DATA ? sreg_n[0] : state_n == PARITY ? par_n : 1'b1;
    end
    assign tx_busy = state != IDLE;
    assign tx_done = state == STOP && tick_end && stop_last;
endmodule
